// File: rtl/unpooler_if.sv
// Stream bundle between the upsampler and its neighbours: pooled input side plus upsampled output side.
// No storage; pure wiring.
// ready_in is driven by the block; valid_in is only consumed when ready_in is high.
interface unpooler_if #(
  parameter int N = 16
);
  logic         valid_in;
  logic [N-1:0] data_in;
  logic         ready_in;
  logic [N-1:0] data_out;
  logic         valid_op;
  logic         end_op;

  // Upstream/downstream environment view
  modport master (
    output valid_in, data_in,
    input  ready_in, data_out, valid_op, end_op
  );

  // Upsampler view
  modport slave (
    input  valid_in, data_in,
    output ready_in, data_out, valid_op, end_op
  );
endinterface

// File: rtl/unpooler.sv
// Nearest-neighbour upsampler: buffers one pooled row of K values and replays it as p output rows of m values.
// Latency: first output of a row group appears 1 ce-cycle after the row's last value is accepted.
// Backpressure: ready_in is low for the whole p*m-cycle replay; ce low freezes everything including outputs.
module unpooler #(
  parameter int m = 12,
  parameter int p = 3,
  parameter int N = 16
) (
  input logic       clk,
  input logic       master_rst,
  input logic       ce,
  unpooler_if.slave bus
);
  localparam int K  = m / p;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (p > 1) ? $clog2(p) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(p - 1);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state;
  logic [KW-1:0] wcol;
  logic [KW-1:0] col;
  logic [KW-1:0] orow;
  logic [PW-1:0] rep;
  logic [PW-1:0] vrep;
  logic [N-1:0]  row_buf [K];
  logic [N-1:0]  data_out_q;
  logic          valid_q;
  logic          end_q;

  logic fill_acc;
  logic group_last;

  // A pooled value is taken only while filling; upstream holds it otherwise.
  assign bus.ready_in = (state == FILL);
  assign fill_acc     = ce && (state == FILL) && bus.valid_in;
  // Last replay of the buffered row: innermost to outermost counters all at their final value.
  assign group_last   = (rep == P_LAST) && (col == K_LAST) && (vrep == P_LAST);

  assign bus.data_out = data_out_q;
  assign bus.valid_op = valid_q;
  assign bus.end_op   = end_q;

  // Row buffer capture; contents deliberately survive reset since they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (master_rst && fill_acc) begin
      row_buf[wcol] <= bus.data_in;
    end
  end

  // Fill/emit sequencer with registered output stage.
  always_ff @(posedge clk) begin
    if (!master_rst) begin
      state      <= FILL;
      wcol       <= '0;
      col        <= '0;
      orow       <= '0;
      rep        <= '0;
      vrep       <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      end_q      <= 1'b0;
    end else if (ce) begin
      case (state)
        FILL: begin
          valid_q <= 1'b0;
          end_q   <= 1'b0;
          if (bus.valid_in) begin
            if (wcol == K_LAST) begin
              wcol  <= '0;
              state <= EMIT;
            end else begin
              wcol <= wcol + KW'(1);
            end
          end
        end
        EMIT: begin
          data_out_q <= row_buf[col];
          valid_q    <= 1'b1;
          end_q      <= 1'b0;
          // rep is the innermost loop, then col, then vrep.
          if (rep == P_LAST) begin
            rep <= '0;
            if (col == K_LAST) begin
              col <= '0;
              if (vrep == P_LAST) begin
                vrep <= '0;
              end else begin
                vrep <= vrep + PW'(1);
              end
            end else begin
              col <= col + KW'(1);
            end
          end else begin
            rep <= rep + PW'(1);
          end
          if (group_last) begin
            state <= FILL;
            if (orow == K_LAST) begin
              end_q <= 1'b1;
              orow  <= '0;
            end else begin
              orow <= orow + KW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/unpooler.md
# unpooler

Nearest-neighbour upsampler that undoes the spatial reduction of the pooling stage. It consumes a (m/p)×(m/p) pooled map in raster order and produces the m×m map in raster order, repeating each pooled value over its p×p window. It sits on the reverse (decoder/upsampling) path and emits the same `valid_op`/`end_op` output convention the pooling stage uses. One row of pooled values is buffered and replayed p times, with backpressure on the input.

## Interface
- `m`, 12: output map side length; must be an integer multiple of `p`.
- `p`, 3: upsampling window side length; ≥1.
- `N`, 16: data bitwidth; values pass through untouched, with no arithmetic.
- Derived: `K = m/p`, the pooled map side length and the row buffer depth.

- `clk` in 1: single clock. All state changes on the rising edge.
- `master_rst` in 1: reset, synchronous and active-low.
- `ce` in 1: global clock enable. When low, all state, counters, buffer and outputs hold.
- `valid_in` in 1: `data_in` carries a pooled value.
- `data_in` in N: pooled value, raster order.
- `ready_in` out 1: block can accept. Combinational, equal to (state==FILL).
- `data_out` out N: upsampled value. Registered.
- `valid_op` out 1: `data_out` is valid this cycle. Registered.
- `end_op` out 1: high for exactly the cycle carrying the last (m²-th) output of a map. Registered.

## Operation
- Storage: row buffer `buf[0..K-1]` of N bits, not cleared by reset.
- Counters:
  - `wcol` (0..K-1): write column.
  - `rep` (0..p-1): horizontal repeat.
  - `col` (0..K-1): read column.
  - `vrep` (0..p-1): vertical repeat.
  - `orow` (0..K-1): pooled row index.
- Reset (`master_rst`=0 at an edge, regardless of `ce`):
  - state=FILL, all counters 0.
  - `data_out`=0, `valid_op`=0, `end_op`=0, so `ready_in`=1.
- FILL state, on a `ce` edge:
  - `valid_op`<=0 and `end_op`<=0.
  - If `valid_in`: `buf[wcol]`<=`data_in`, then `wcol`++.
  - Accepting the element at `wcol`=K-1 sets `wcol`<=0 and state<=EMIT.
  - Gaps in `valid_in` are allowed; `wcol` holds across them.
- EMIT state, on a `ce` edge:
  - `data_out`<=`buf[col]`, `valid_op`<=1.
  - Counters advance as a nest: `rep` is the innermost, then `col`, then `vrep`.
  - Each counter wraps to 0 and carries into the next.
- Leaving EMIT, at the edge emitting the last output of a row group (`rep`=p-1, `col`=K-1, `vrep`=p-1):
  - If `orow`=K-1: `end_op`<=1 with that output, `orow`<=0, state<=FILL. The next map starts with no idle state.
  - Otherwise: `orow`++, state<=FILL.
- Input during EMIT:
  - `ready_in`=0, so `valid_in` is ignored and nothing is consumed.
  - The upstream holds its data, or sits behind a FIFO. The pooling stage has no backpressure, so a FIFO of ≥K·p·m entries goes between them when they are chained.
- Output mapping: output (r,c) = input (r/p, c/p), using integer division.
- States: FILL and EMIT only.
- Transitions:
  - FILL→EMIT on the K-th accepted element.
  - EMIT→FILL after p·m emissions.
  - Any state→FILL on reset.

## Timing
- Accept: data is captured at a `ce` edge with `valid_in`=1 and `ready_in`=1.
- Latency: the first output of a row group is visible after the first `ce` edge following acceptance of the row's last element. That is 1 cycle after the accepting edge.
- Throughput, per pooled row: K accept cycles + p·m emit cycles.
- Whole map with unstalled input: K·(K+p·m) cycles. With the defaults this is 4·(4+36)=160 cycles for 144 outputs.
- `valid_op`:
  - Continuous for p·m cycles per row group.
  - Drops to 0 at the first FILL edge after a group.
- `end_op`: exactly one cycle per map, coincident with `valid_op`=1.
- `ce` low:
  - Outputs keep their last value, including `valid_op`=1.
  - Downstream qualifies samples with `ce`.
  - No output is lost or duplicated.
- Reset mid-EMIT or mid-FILL:
  - Partial row and map are abandoned.
  - `valid_op`=0 and `ready_in`=1 after the reset edge.
  - The next accepted value is element (0,0) of a new map.
- Boundary case p=1: each input row is replayed once, so the block acts as a 1-row store-and-forward.

## Test plan
- Reset: hold `master_rst`=0 for 2 cycles. Expect `valid_op`=0, `end_op`=0, `data_out`=0, `ready_in`=1.
- Single row (m=12, p=3): feed 0x0001..0x0004 back-to-back.
  - `ready_in` falls after the 4th value.
  - Outputs are 1,1,1,2,2,2,3,3,3,4,4,4, repeated 3 times, with 36 consecutive `valid_op`.
  - `ready_in` returns to 1 after that.
- Full map: input k=0..15 as value 0x0100+k.
  - 144 outputs, each (r,c) = 0x0100+4·(r/3)+c/3.
  - `end_op` high only on output 144; total 160 cycles.
  - A second map follows immediately and is correct.
- `ce` gating: drop `ce` for 5 cycles after output 10 of a row group.
  - `data_out`, `valid_op` and counters frozen.
  - Resumes with output 11 value; 36 outputs total.
- Backpressure: hold `valid_in`=1 with data incrementing every cycle during EMIT.
  - No capture during EMIT.
  - First value of the next row = `data_in` present on the first FILL edge.
- Reset after output 10 of row 1. Expect:
  - `valid_op`=0 and `ready_in`=1 next cycle.
  - A fresh full map is reproduced exactly, with `end_op` on output 144.
